// File: rtl/div_int24.sv
// -----------------------------------------------------------------------------
// div_int24 - iterative 24-bit integer divider (radix-2 restoring)
//
// Companion to the 24-bit pipelined multiplier in the arithmetic unit. One
// dividend/divisor pair is accepted at a time. The core runs 24 restoring
// iterations on operand magnitudes, then applies sign correction. It returns a
// quotient that truncates toward zero and a remainder that takes the sign of
// the dividend.
//
// Ports
//   clock       in   1   rising-edge clock
//   reset       in   1   synchronous, active-high; aborts any operation
//   en          in   1   start request, honoured only in IDLE
//   opcode      in   2   2'b00 unsigned, 2'b11 signed, others reserved
//   dividend    in  24   numerator, sampled with en
//   divisor     in  24   denominator, sampled with en
//   busy        out  1   high in CALC and FIX
//   done        out  1   one-cycle pulse; results valid from this cycle on
//   quotient    out 24   held until the next done
//   remainder   out 24   held until the next done
//   div_by_zero out  1   qualifies the held results
// -----------------------------------------------------------------------------
module div_int24 (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  opcode,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [23:0] quotient,
  output logic [23:0] remainder,
  output logic        div_by_zero
);

  // Opcode encodings shared with the multiplier
  localparam logic [1:0] UNSIGNED_DIV = 2'b00;
  localparam logic [1:0] SIGNED_DIV   = 2'b11;

  localparam logic [4:0] LAST_STEP = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Datapath registers
  logic [23:0] dq_reg;        // dividend magnitude shifting out, quotient shifting in
  logic [24:0] rem_reg;       // partial remainder
  logic [23:0] dvs_reg;       // divisor magnitude
  logic [4:0]  count_reg;     // iteration counter
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic [23:0] quotient_reg;
  logic [23:0] remainder_reg;
  logic        dbz_reg;

  // Start decode
  logic        op_valid;
  logic        op_signed;
  logic        start_div;     // accept, normal path
  logic        start_zero;    // accept, divide-by-zero path
  logic [23:0] dividend_mag;
  logic [23:0] divisor_mag;

  // One restoring step
  logic [24:0] rem_shift;
  logic [25:0] diff;
  logic        take;
  logic [24:0] rem_step;
  logic [23:0] dq_step;

  always_comb begin
    op_valid  = (opcode == UNSIGNED_DIV) || (opcode == SIGNED_DIV);
    op_signed = (opcode == SIGNED_DIV);

    start_div  = (state_reg == IDLE) && en && op_valid && (divisor != 24'd0);
    start_zero = (state_reg == IDLE) && en && op_valid && (divisor == 24'd0);

    // Two's-complement negation; -2^23 stays 0x800000 and is then used as an
    // unsigned magnitude, which is what makes (-2^23)/(-1) come out right.
    dividend_mag = (op_signed && dividend[23]) ? (24'd0 - dividend) : dividend;
    divisor_mag  = (op_signed && divisor[23])  ? (24'd0 - divisor)  : divisor;
  end

  always_comb begin
    rem_shift = {rem_reg[23:0], dq_reg[23]};
    // One extra bit so the borrow shows up as a sign bit
    diff      = {1'b0, rem_shift} - {2'b00, dvs_reg};
    take      = ~diff[25];
    rem_step  = take ? diff[24:0] : rem_shift;
    dq_step   = {dq_reg[22:0], take};
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_div) begin
          state_next = CALC;
        end else if (start_zero) begin
          state_next = DONE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count_reg == LAST_STEP) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      dq_reg        <= 24'd0;
      rem_reg       <= 25'd0;
      dvs_reg       <= 24'd0;
      count_reg     <= 5'd0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      quotient_reg  <= 24'd0;
      remainder_reg <= 24'd0;
      dbz_reg       <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_div) begin
            dq_reg    <= dividend_mag;
            rem_reg   <= 25'd0;
            dvs_reg   <= divisor_mag;
            count_reg <= 5'd0;
            q_neg_reg <= op_signed && (dividend[23] ^ divisor[23]);
            r_neg_reg <= op_signed && dividend[23];
          end else if (start_zero) begin
            // Divide by zero bypasses the iteration; results land together
            // with the DONE pulse in the next cycle.
            quotient_reg  <= 24'hFF_FFFF;
            remainder_reg <= dividend;
            dbz_reg       <= 1'b1;
          end
        end
        CALC: begin
          rem_reg   <= rem_step;
          dq_reg    <= dq_step;
          count_reg <= count_reg + 5'd1;
        end
        FIX: begin
          // Remainder is always below the divisor magnitude, so bit 24 is zero.
          quotient_reg  <= q_neg_reg ? (24'd0 - dq_reg) : dq_reg;
          remainder_reg <= r_neg_reg ? (24'd0 - rem_reg[23:0]) : rem_reg[23:0];
          dbz_reg       <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_int24.sv
// -----------------------------------------------------------------------------
// tb_div_int24 - directed, self-checking bench for div_int24
//
// Operations are issued one at a time. Each one's latency, busy span, results
// and the single done pulse are compared against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_div_int24;

  logic        clock;
  logic        reset;
  logic        en;
  logic [1:0]  opcode;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        busy;
  logic        done;
  logic [23:0] quotient;
  logic [23:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  logic [23:0] last_q;
  logic [23:0] last_r;

  div_int24 dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .opcode      (opcode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation (called just after a rising edge) and follow it to
  // completion. inject pulses en at d5 and d26, both of which must be ignored.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [23:0] a, input logic [23:0] b, input bit inject,
                        input logic [23:0] exp_q, input logic [23:0] exp_r,
                        input logic exp_dz, input int exp_lat);
    int cyc;
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    opcode   = op;
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock);
      #1;
      en = inject && (cyc == 5 || cyc == 26);
      if (inject) begin
        dividend = 24'd50;
        divisor  = 24'd5;
      end
      if (cyc == 1 && exp_lat > 1) begin
        check({name, " q_stable"}, {8'd0, quotient}, {8'd0, last_q});
      end
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({name, " latency"},   lat,      exp_lat);
    check({name, " busy_span"}, busy_cnt, exp_lat - 1);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, " quotient"},  {8'd0, quotient},  {8'd0, exp_q});
    check({name, " remainder"}, {8'd0, remainder}, {8'd0, exp_r});
    check({name, " dbz"},       {31'd0, div_by_zero}, {31'd0, exp_dz});
    @(posedge clock);
    #1;
    en = 1'b0;
    check({name, " done_once"}, {31'd0, done}, 32'd0);
    check({name, " idle_after"}, {31'd0, busy}, 32'd0);
    check({name, " q_hold"}, {8'd0, quotient}, {8'd0, exp_q});
    last_q = exp_q;
    last_r = exp_r;
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    reset    = 1'b1;
    en       = 1'b0;
    opcode   = 2'b00;
    dividend = 24'd0;
    divisor  = 24'd0;
    last_q   = 24'd0;
    last_r   = 24'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quotient", {8'd0, quotient}, 32'd0);
    check("rst remainder", {8'd0, remainder}, 32'd0);
    check("rst dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // name, op, dividend, divisor, inject, quotient, remainder, dbz, latency
    run_op("u100/7",      2'b00, 24'd100,     24'd7,       1'b0, 24'd14,      24'd2,       1'b0, 26);
    $display("op u100/7 q=%0d r=%0d", quotient, remainder);
    run_op("s-7/2",       2'b11, 24'hFFFFF9,  24'h000002,  1'b0, 24'hFFFFFD,  24'hFFFFFF,  1'b0, 26);
    $display("op s-7/2 q=%h r=%h", quotient, remainder);
    run_op("s7/-2",       2'b11, 24'h000007,  24'hFFFFFE,  1'b0, 24'hFFFFFD,  24'h000001,  1'b0, 26);
    $display("op s7/-2 q=%h r=%h", quotient, remainder);
    run_op("s_ovf",       2'b11, 24'h800000,  24'hFFFFFF,  1'b0, 24'h800000,  24'h000000,  1'b0, 26);
    $display("op s_ovf q=%h r=%h", quotient, remainder);
    run_op("u_max/1",     2'b00, 24'hFFFFFF,  24'h000001,  1'b0, 24'hFFFFFF,  24'h000000,  1'b0, 26);
    $display("op u_max/1 q=%h r=%h", quotient, remainder);
    run_op("u_div0",      2'b00, 24'h123456,  24'h000000,  1'b0, 24'hFFFFFF,  24'h123456,  1'b1, 1);
    $display("op u_div0 q=%h r=%h dbz=%0d", quotient, remainder, div_by_zero);
    run_op("u100/7_inj",  2'b00, 24'd100,     24'd7,       1'b1, 24'd14,      24'd2,       1'b0, 26);
    $display("op u100/7_inj q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
    run_op("s_div0",      2'b11, 24'hFFFFF9,  24'h000000,  1'b0, 24'hFFFFFF,  24'hFFFFF9,  1'b1, 1);
    $display("op s_div0 q=%h r=%h dbz=%0d", quotient, remainder, div_by_zero);

    // Reserved opcode: request ignored, outputs unchanged
    opcode   = 2'b01;
    dividend = 24'd100;
    divisor  = 24'd7;
    en       = 1'b1;
    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      en = 1'b0;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("rsv busy", busy_seen, 0);
    check("rsv done", done_seen, 0);
    check("rsv quotient", {8'd0, quotient}, {8'd0, last_q});
    check("rsv remainder", {8'd0, remainder}, {8'd0, last_r});
    $display("op reserved busy=%0d done=%0d", busy_seen, done_seen);

    // Reset at d10 of an operation
    opcode   = 2'b00;
    dividend = 24'd1000;
    divisor  = 24'd10;
    en       = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clock);
      #1;
      en = 1'b0;
      if (cyc == 9) check("rst_mid busy_before", {31'd0, busy}, 32'd1);
      if (cyc == 10) reset = 1'b1;
    end
    @(posedge clock);
    #1;
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid done", {31'd0, done}, 32'd0);
    check("rst_mid quotient", {8'd0, quotient}, 32'd0);
    check("rst_mid remainder", {8'd0, remainder}, 32'd0);
    check("rst_mid dbz", {31'd0, div_by_zero}, 32'd0);
    $display("op reset_mid q=%h r=%h busy=%0d", quotient, remainder, busy);
    reset  = 1'b0;
    last_q = 24'd0;
    last_r = 24'd0;
    run_op("u1000/10",    2'b00, 24'd1000,    24'd10,      1'b0, 24'd100,     24'd0,       1'b0, 26);
    $display("op u1000/10 q=%0d r=%0d", quotient, remainder);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
